// File: rtl/mcu51_fetch_pkg.sv
// Shared constants for the MCU51 instruction-fetch stage: jump source codes,
// reset values and PC_CON bit positions.
package mcu51_fetch_pkg;

  localparam logic [1:0] JMP_ABS11  = 2'b00;
  localparam logic [1:0] JMP_LONG16 = 2'b01;
  localparam logic [1:0] JMP_IND    = 2'b10;
  localparam logic [1:0] JMP_RSVD   = 2'b11;

  localparam logic [7:0]  NOP_OPCODE   = 8'h00;
  localparam logic [15:0] RESET_VECTOR = 16'h0000;

  // PC_CON = {PC_en, Jump_flag, PC_add_rel}
  localparam int PC_EN_BIT   = 2;
  localparam int JUMP_BIT    = 1;
  localparam int ADD_REL_BIT = 0;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: increment, relative branch or absolute jump.
// Holds the PC when PC_en is low or the jump source is reserved.
module fetch_pc_next
  import mcu51_fetch_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [2:0]  pc_con,
  input  logic [1:0]  jmp_sel,
  input  logic [7:0]  ir,
  input  logic [7:0]  direct,
  input  logic [7:0]  rel,
  input  logic [7:0]  code_data,
  input  logic [15:0] jump_target,
  output logic [15:0] pc_next,
  output logic        wrap
);

  always_comb begin
    pc_next = pc;
    wrap    = 1'b0;
    if (pc_con[PC_EN_BIT]) begin
      if (!pc_con[JUMP_BIT]) begin
        pc_next = pc + 16'd1;
        wrap    = (pc == 16'hFFFF);
      end else if (pc_con[ADD_REL_BIT]) begin
        pc_next = pc + {{8{rel[7]}}, rel};
      end else begin
        case (jmp_sel)
          JMP_ABS11:  pc_next = {pc[15:11], ir[7:5], direct};
          JMP_LONG16: pc_next = {direct, code_data};
          JMP_IND:    pc_next = jump_target;
          default:    pc_next = pc;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MCU51 fetch stage: program counter, code address and the opcode/operand
// latches that feed CU, plus sticky wrap and fetch-error flags.
module fetch_unit
  import mcu51_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = mcu51_fetch_pkg::RESET_VECTOR,
  parameter logic [7:0]  NOP_OPCODE   = mcu51_fetch_pkg::NOP_OPCODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PC_CON,
  input  logic [1:0]  jmp_sel,
  input  logic [15:0] jump_target,
  input  logic        CODE_CS,
  input  logic        IR_en,
  input  logic        direct_en,
  input  logic        rel_en,
  input  logic        bit_en,
  input  logic [7:0]  code_data,
  output logic [15:0] code_addr,
  output logic [7:0]  IR,
  output logic [7:0]  direct,
  output logic [7:0]  rel,
  output logic [7:0]  bit_addr,
  output logic [15:0] inst_pc,
  output logic [1:0]  byte_idx,
  output logic        pc_wrap,
  output logic        fetch_err
);

  logic [15:0] pc, pc_next;
  logic        wrap_now;
  logic        op_en, any_en;

  assign code_addr = pc;
  assign op_en     = direct_en | rel_en | bit_en;
  assign any_en    = IR_en | op_en;

  fetch_pc_next u_pc_next (
    .pc          (pc),
    .pc_con      (PC_CON),
    .jmp_sel     (jmp_sel),
    .ir          (IR),
    .direct      (direct),
    .rel         (rel),
    .code_data   (code_data),
    .jump_target (jump_target),
    .pc_next     (pc_next),
    .wrap        (wrap_now)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      IR        <= NOP_OPCODE;
      direct    <= 8'h00;
      rel       <= 8'h00;
      bit_addr  <= 8'h00;
      inst_pc   <= 16'h0000;
      byte_idx  <= 2'd0;
      pc_wrap   <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      pc <= pc_next;
      if (wrap_now) pc_wrap <= 1'b1;
      if (any_en && !CODE_CS) fetch_err <= 1'b1;
      // An opcode fetch starts a new instruction, so it overrides operand latches.
      if (CODE_CS && IR_en) begin
        IR       <= code_data;
        inst_pc  <= pc;
        byte_idx <= 2'd1;
      end else if (CODE_CS && op_en) begin
        if (direct_en) direct   <= code_data;
        if (rel_en)    rel      <= code_data;
        if (bit_en)    bit_addr <= code_data;
        byte_idx <= (byte_idx == 2'd3) ? 2'd3 : byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: a table of per-cycle stimulus with
// hand-computed expected state, then hand sequences for multi-cycle corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PC_CON;
  logic [1:0]  jmp_sel;
  logic [15:0] jump_target;
  logic        CODE_CS;
  logic        IR_en, direct_en, rel_en, bit_en;
  logic [7:0]  code_data;
  logic [15:0] code_addr;
  logic [7:0]  IR, direct, rel, bit_addr;
  logic [15:0] inst_pc;
  logic [1:0]  byte_idx;
  logic        pc_wrap, fetch_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .PC_CON(PC_CON), .jmp_sel(jmp_sel),
    .jump_target(jump_target), .CODE_CS(CODE_CS), .IR_en(IR_en),
    .direct_en(direct_en), .rel_en(rel_en), .bit_en(bit_en),
    .code_data(code_data), .code_addr(code_addr), .IR(IR), .direct(direct),
    .rel(rel), .bit_addr(bit_addr), .inst_pc(inst_pc), .byte_idx(byte_idx),
    .pc_wrap(pc_wrap), .fetch_err(fetch_err)
  );

  typedef struct packed {
    logic [15:0] ca;
    logic [7:0]  ir, di, re, bi;
    logic [15:0] ip;
    logic [1:0]  bx;
    logic        w, e;
  } out_t;

  typedef struct {
    logic        rst;
    logic [2:0]  pc_con;
    logic [1:0]  jsel;
    logic [15:0] jt;
    logic        cs;
    logic [3:0]  en;   // {IR_en, direct_en, rel_en, bit_en}
    logic [7:0]  cd;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [2:0] pc_con, logic [1:0] jsel,
                              logic [15:0] jt, logic cs, logic [3:0] en, logic [7:0] cd,
                              logic [15:0] ca, logic [7:0] ir, logic [7:0] di,
                              logic [7:0] re, logic [7:0] bi, logic [15:0] ip,
                              logic [1:0] bx, logic w, logic e);
    vec_t v;
    v.rst = rst; v.pc_con = pc_con; v.jsel = jsel; v.jt = jt;
    v.cs = cs; v.en = en; v.cd = cd;
    v.exp = '{ca: ca, ir: ir, di: di, re: re, bi: bi, ip: ip, bx: bx, w: w, e: e};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    reset = v.rst; PC_CON = v.pc_con; jmp_sel = v.jsel; jump_target = v.jt;
    CODE_CS = v.cs; {IR_en, direct_en, rel_en, bit_en} = v.en; code_data = v.cd;
  endtask

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = '{ca: code_addr, ir: IR, di: direct, re: rel, bi: bit_addr,
            ip: inst_pc, bx: byte_idx, w: pc_wrap, e: fetch_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ca=%h ir=%h di=%h re=%h bi=%h ip=%h bx=%0d w=%b e=%b, want ca=%h ir=%h di=%h re=%h bi=%h ip=%h bx=%0d w=%b e=%b",
               name, act.ca, act.ir, act.di, act.re, act.bi, act.ip, act.bx, act.w, act.e,
               exp.ca, exp.ir, exp.di, exp.re, exp.bi, exp.ip, exp.bx, exp.w, exp.e);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    chk(name, v.exp);
  endtask

  initial begin
    vec_t v;
    out_t x;

    // reset held 3 cycles, with PC_en asserted to show reset wins
    repeat (3) vecs.push_back(mk(1, 3'b100, 2'b00, 16'h0, 1, 4'b0000, 8'h00,
                                 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h0001, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h0002, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h0003, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h0004, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0));
    // opcode + direct fetch at 0010, PC incrementing alongside
    vecs.push_back(mk(0, 3'b110, 2'b10, 16'h0010, 1, 4'b0000, 8'h00, 16'h0010, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b1000, 8'h74, 16'h0011, 8'h74, 8'h00, 8'h00, 8'h00, 16'h0010, 1, 0, 0));
    vecs.push_back(mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b0100, 8'h55, 16'h0012, 8'h74, 8'h55, 8'h00, 8'h00, 16'h0010, 2, 0, 0));
    // relative branches
    vecs.push_back(mk(0, 3'b000, 2'b00, 16'h0, 1, 4'b0010, 8'hFE, 16'h0012, 8'h74, 8'h55, 8'hFE, 8'h00, 16'h0010, 3, 0, 0));
    vecs.push_back(mk(0, 3'b110, 2'b10, 16'h0020, 1, 4'b0000, 8'h00, 16'h0020, 8'h74, 8'h55, 8'hFE, 8'h00, 16'h0010, 3, 0, 0));
    vecs.push_back(mk(0, 3'b111, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h001E, 8'h74, 8'h55, 8'hFE, 8'h00, 16'h0010, 3, 0, 0));
    // rel_en with a branch: branch uses old FE, byte_idx saturates at 3
    vecs.push_back(mk(0, 3'b111, 2'b00, 16'h0, 1, 4'b0010, 8'h7F, 16'h001C, 8'h74, 8'h55, 8'h7F, 8'h00, 16'h0010, 3, 0, 0));
    vecs.push_back(mk(0, 3'b110, 2'b10, 16'h0020, 1, 4'b0000, 8'h00, 16'h0020, 8'h74, 8'h55, 8'h7F, 8'h00, 16'h0010, 3, 0, 0));
    vecs.push_back(mk(0, 3'b111, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h009F, 8'h74, 8'h55, 8'h7F, 8'h00, 16'h0010, 3, 0, 0));
    // absolute jumps
    vecs.push_back(mk(0, 3'b000, 2'b00, 16'h0, 1, 4'b1000, 8'hE1, 16'h009F, 8'hE1, 8'h55, 8'h7F, 8'h00, 16'h009F, 1, 0, 0));
    vecs.push_back(mk(0, 3'b000, 2'b00, 16'h0, 1, 4'b0100, 8'h34, 16'h009F, 8'hE1, 8'h34, 8'h7F, 8'h00, 16'h009F, 2, 0, 0));
    vecs.push_back(mk(0, 3'b110, 2'b10, 16'h1234, 1, 4'b0000, 8'h00, 16'h1234, 8'hE1, 8'h34, 8'h7F, 8'h00, 16'h009F, 2, 0, 0));
    vecs.push_back(mk(0, 3'b110, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h1734, 8'hE1, 8'h34, 8'h7F, 8'h00, 16'h009F, 2, 0, 0));
    vecs.push_back(mk(0, 3'b000, 2'b00, 16'h0, 1, 4'b0100, 8'hAB, 16'h1734, 8'hE1, 8'hAB, 8'h7F, 8'h00, 16'h009F, 3, 0, 0));
    vecs.push_back(mk(0, 3'b110, 2'b01, 16'h0, 1, 4'b0000, 8'hCD, 16'hABCD, 8'hE1, 8'hAB, 8'h7F, 8'h00, 16'h009F, 3, 0, 0));
    vecs.push_back(mk(0, 3'b110, 2'b10, 16'h0F00, 1, 4'b0000, 8'h00, 16'h0F00, 8'hE1, 8'hAB, 8'h7F, 8'h00, 16'h009F, 3, 0, 0));
    vecs.push_back(mk(0, 3'b110, 2'b11, 16'h5555, 1, 4'b0000, 8'h66, 16'h0F00, 8'hE1, 8'hAB, 8'h7F, 8'h00, 16'h009F, 3, 0, 0));
    // PC_en low holds the PC
    vecs.push_back(mk(0, 3'b010, 2'b10, 16'h5555, 1, 4'b0000, 8'h00, 16'h0F00, 8'hE1, 8'hAB, 8'h7F, 8'h00, 16'h009F, 3, 0, 0));
    // wrap from FFFF
    vecs.push_back(mk(0, 3'b110, 2'b10, 16'hFFFF, 1, 4'b0000, 8'h00, 16'hFFFF, 8'hE1, 8'hAB, 8'h7F, 8'h00, 16'h009F, 3, 0, 0));
    vecs.push_back(mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b0000, 8'h00, 16'h0000, 8'hE1, 8'hAB, 8'h7F, 8'h00, 16'h009F, 3, 1, 0));

    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

    // pc_wrap stays set across 10 more increments
    x = vecs[vecs.size()-1].exp;
    v = vecs[vecs.size()-1];
    for (int i = 1; i <= 10; i++) begin
      x.ca = 16'(i);
      v.exp = x;
      step($sformatf("wrap_sticky%0d", i), v);
    end

    // opcode latch with CODE_CS low: suppressed, fetch_err set
    v = mk(0, 3'b000, 2'b00, 16'h0, 0, 4'b1000, 8'h99, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 16'h0, 0, 0, 0);
    x.e = 1'b1;
    v.exp = x;
    step("cs_low", v);

    // opcode and operand in the same cycle: opcode wins
    v = mk(0, 3'b000, 2'b00, 16'h0, 1, 4'b1100, 8'hE3, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 16'h0, 0, 0, 0);
    x.ir = 8'hE3; x.ip = 16'h000A; x.bx = 2'd1;
    v.exp = x;
    step("ir_and_direct", v);

    // two operand enables: both load, byte_idx steps once
    v = mk(0, 3'b000, 2'b00, 16'h0, 1, 4'b0011, 8'h5A, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0, 16'h0, 0, 0, 0);
    x.re = 8'h5A; x.bi = 8'h5A; x.bx = 2'd2;
    v.exp = x;
    step("rel_and_bit", v);

    // reset mid-operand discards everything, including sticky flags
    v = mk(1, 3'b100, 2'b00, 16'h0, 1, 4'b0100, 8'h11,
           16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0);
    step("mid_reset", v);
    v = mk(0, 3'b100, 2'b00, 16'h0, 1, 4'b0000, 8'h00,
           16'h0001, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 0);
    step("post_reset", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MCU51 core. It sits directly upstream of CU and supplies CU's `IR` and `direct` inputs.
- Holds the 16-bit program counter and drives the code-memory address.
- Latches the opcode and operand bytes (direct, rel, bit) from the code bus under the CU enables `IR_en`, `direct_en`, `rel_en` and `bit_en`.
- Executes the CU's `PC_CON` commands: increment, relative branch, absolute/long/indirect jump.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- NOP_OPCODE, 8'h00, IR value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- PC_CON  input  3  {PC_en, Jump_flag, PC_add_rel} from CU.
- jmp_sel  input  2  absolute-jump source, used only when Jump_flag=1 and PC_add_rel=0.
- jump_target  input  16  indirect target, e.g. A+DPTR.
- CODE_CS  input  1  code memory selected; qualifies every latch enable.
- IR_en  input  1  latch opcode.
- direct_en  input  1  latch direct operand.
- rel_en  input  1  latch rel operand.
- bit_en  input  1  latch bit operand.
- code_data  input  8  byte read from code memory at code_addr.
- code_addr  output  16  equals PC (combinational from the PC register).
- IR  output  8  opcode register, to CU.
- direct  output  8  direct/immediate/addr-hi operand, to CU and datapath.
- rel  output  8  relative offset register.
- bit_addr  output  8  bit-address operand.
- inst_pc  output  16  PC of the opcode byte of the current instruction.
- byte_idx  output  2  bytes latched for the current instruction, 0..3.
- pc_wrap  output  1  sticky: PC incremented from 16'hFFFF.
- fetch_err  output  1  sticky: a latch enable was asserted while CODE_CS=0.

Behaviour:
- **Reset** (synchronous, highest priority):
  - PC=RESET_VECTOR, IR=NOP_OPCODE.
  - direct=rel=bit_addr=8'h00, inst_pc=16'h0000, byte_idx=0, pc_wrap=0, fetch_err=0.
  - Reset asserted mid-instruction discards all partial state on that edge.
- **PC update**, when PC_en=1; PC holds when PC_en=0:
  - Jump_flag=0: PC <= PC+1, modulo 2^16. The step 16'hFFFF -> 16'h0000 sets pc_wrap.
  - Jump_flag=1, PC_add_rel=1: PC <= PC + sign_extend16(rel). Use the rel register value before this edge; no wrap flag.
  - Jump_flag=1, PC_add_rel=0, jmp_sel=00 (abs11): PC <= {PC[15:11], IR[7:5], direct}.
  - jmp_sel=01 (long16): PC <= {direct, code_data}.
  - jmp_sel=10 (indirect): PC <= jump_target.
  - jmp_sel=11 (reserved): PC holds.
- **Latches**, each qualified by CODE_CS=1:
  - IR_en: IR <= code_data; inst_pc <= PC (the pre-edge value); byte_idx <= 1.
  - Any of direct_en/rel_en/bit_en: load the corresponding register from code_data; byte_idx <= min(byte_idx+1, 3).
  - Two operand enables in one cycle both load, and byte_idx increments once.
- **Simultaneous events:**
  - IR_en together with any operand enable: IR_en wins; operand registers hold and byte_idx=1.
  - IR_en with PC_en: both take effect.
  - rel_en with a relative jump: the jump uses the old rel, and rel updates.
- **CODE_CS=0 with any latch enable:** the latch is suppressed, registers hold, fetch_err is set.
- **Sticky flags:** cleared only by reset.
- **Latency:** all outputs except code_addr are registered, one cycle after the enabling edge. code_addr follows PC with no added delay.
- **Width rules:** all PC arithmetic is 16-bit unsigned with silent truncation. rel is two's complement, range -128..+127.

Decomposition:
- Package mcu51_fetch_pkg:
  - jmp_sel codes JMP_ABS11=2'b00, JMP_LONG16=2'b01, JMP_IND=2'b10, JMP_RSVD=2'b11.
  - NOP_OPCODE and RESET_VECTOR constants.
  - PC_CON bit indices.
- One sub-module, fetch_pc_next: a purely combinational next-PC mux.
  - Inputs: PC, PC_CON, jmp_sel, IR, direct, rel, code_data, jump_target.
  - Outputs: pc_next and the wrap indication.
  - fetch_unit keeps all registers.

Test Plan:
1. Reset held 3 cycles, then released with PC_CON=3'b100 for 4 cycles -> during reset code_addr=0000, IR=00, byte_idx=0; after release code_addr steps 0001..0004.
2. Fetch at PC=0010 with code_data=74, IR_en=1; next cycle code_data=55, direct_en=1 -> IR=74, inst_pc=0010, direct=55, byte_idx=2.
3. rel=FE latched, PC=0020, PC_CON=3'b111 -> PC=001E; with rel=7F -> PC=009F.
4. Jumps:
   - IR=E1, direct=34, PC=1234, abs11 jump -> PC=1734.
   - long16 with direct=AB, code_data=CD -> PC=ABCD.
   - indirect with jump_target=0F00 -> PC=0F00.
   - jmp_sel=11 -> PC unchanged.
5. PC=FFFF, PC_CON=3'b100 -> PC=0000 and pc_wrap=1, remaining 1 through 10 later increments. IR_en with CODE_CS=0 -> IR unchanged and fetch_err=1.
6. IR_en and direct_en in the same cycle (code_data=E3) -> IR=E3, direct unchanged, byte_idx=1. Then reset asserted mid-operand -> all outputs return to reset values on that edge.
